alu_share_ctrl: RTL and testbench

- Shares one combinational 16-bit `alu` instance between two independent requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. ALU operands are registered; the result and carry are captured and held until the owner accepts them.
- Sits between the datapath's two issuing units (e.g. address unit, execute unit) and the shared ALU.

---
 rtl/alu_share_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters share one combinational 16-bit ALU.
// Round-robin arbitration. Operands, result and carry are registered, and the
// result is held until the owning requester takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; one requester may be granted this cycle
// EXEC  | operands driven to the ALU, waiting ALU_LAT cycles
// RESP  | result held, rsp_valid high to the owner until it is taken
module alu_share_ctrl #(
   parameter int ALU_LAT   = 1,
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_op,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_data,
   output logic        rsp0_carry,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_op,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_data,
   output logic        rsp1_carry,

   output logic [2:0]  alu_op,
   output logic [15:0] alu_i0,
   output logic [15:0] alu_i1,
   input  logic [15:0] alu_o,
   input  logic        alu_carry,

   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // EXEC counter load value: the capture happens in the cycle the count is 0
   localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

   generate
      if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
         $error("alu_share_ctrl: ALU_LAT must be within 1..15");
      end
   endgenerate

   state_t      state;
   state_t      state_nxt;

   logic        ptr;
   logic        owner_q;
   logic [3:0]  cnt;
   logic [2:0]  op_q;
   logic [15:0] i0_q;
   logic [15:0] i1_q;
   logic [15:0] res_q;
   logic        carry_q;

   logic        grant0;
   logic        grant1;
   logic        accept;
   logic        capture;
   logic        release_rsp;
   logic        owner_rsp_ready;

   assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode, grant selection and per-cycle strobes
   always_comb begin
      state_nxt   = state;
      grant0      = 1'b0;
      grant1      = 1'b0;
      accept      = 1'b0;
      capture     = 1'b0;
      release_rsp = 1'b0;
      case (state)
         IDLE: begin
            // the pointer requester wins a tie; a lone requester always wins
            grant0 = req0_valid & (~ptr | ~req1_valid);
            grant1 = req1_valid & ( ptr | ~req0_valid);
            if (grant0 || grant1) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (owner_rsp_ready) begin
               release_rsp = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand registers, owner and EXEC down-counter; operands only change on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= 3'd0;
         i0_q    <= 16'd0;
         i1_q    <= 16'd0;
         owner_q <= 1'b0;
         cnt     <= 4'd0;
      end else if (accept) begin
         op_q    <= grant1 ? req1_op : req0_op;
         i0_q    <= grant1 ? req1_a  : req0_a;
         i1_q    <= grant1 ? req1_b  : req0_b;
         owner_q <= grant1;
         cnt     <= LAT_LAST;
      end else if (state == EXEC && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Result capture; the ALU carry path only looks at op[0], so keep carry for add/sub only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= 16'd0;
         carry_q <= 1'b0;
      end else if (capture) begin
         res_q   <= alu_o;
         carry_q <= alu_carry & (op_q[2:1] == 2'b00);
      end
   end

   // Round-robin pointer: the requester that was not just served gets priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PRIO_INIT;
      end else if (release_rsp) begin
         ptr <= ~owner_q;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign rsp0_valid = (state == RESP) & ~owner_q;
   assign rsp1_valid = (state == RESP) &  owner_q;

   // both requesters see the same held result; only the owner's valid qualifies it
   assign rsp0_data  = res_q;
   assign rsp1_data  = res_q;
   assign rsp0_carry = carry_q;
   assign rsp1_carry = carry_q;

   assign alu_op = op_q;
   assign alu_i0 = i0_q;
   assign alu_i1 = i1_q;

   assign busy  = (state != IDLE);
   assign owner = owner_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: two instances (ALU_LAT=1/PRIO_INIT=0 and
// ALU_LAT=4/PRIO_INIT=1), each with a behavioural ALU stub, directed scenario
// tasks and a randomized run against a transaction-level reference model.
module tb_alu_share_ctrl;

   localparam int NI = 2;

   logic        clk;
   logic        rst_n     [NI];
   logic        req_valid [NI][2];
   logic        req_ready [NI][2];
   logic [2:0]  req_op    [NI][2];
   logic [15:0] req_a     [NI][2];
   logic [15:0] req_b     [NI][2];
   logic        rsp_valid [NI][2];
   logic        rsp_ready [NI][2];
   logic [15:0] rsp_data  [NI][2];
   logic        rsp_carry [NI][2];
   logic [2:0]  alu_op    [NI];
   logic [15:0] alu_i0    [NI];
   logic [15:0] alu_i1    [NI];
   logic [15:0] alu_o     [NI];
   logic        alu_carry [NI];
   logic        busy      [NI];
   logic        owner     [NI];

   int checks   = 0;
   int failures = 0;

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic int prio_of(input int i);
      return (i == 0) ? 0 : 1;
   endfunction

   // ALU stand-in: carry path decodes op[0] only (add carry or sub no-borrow)
   function automatic logic [16:0] alu_stub(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] o;
      s = op[0] ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
      case (op)
         3'b000, 3'b001: o = s[15:0];
         3'b010:         o = a & b;
         3'b011:         o = a | b;
         3'b100:         o = a << b[3:0];
         3'b101:         o = a >> b[3:0];
         3'b110:         o = $signed(a) >>> b[3:0];
         default:        o = {15'd0, a < b};
      endcase
      return {s[16], o};
   endfunction

   // Expected {carry, data} for a transaction, from plain integer arithmetic
   function automatic logic [16:0] ref_rsp(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      int   ua, ub, sh, r;
      logic cy;
      ua = int'(a);
      ub = int'(b);
      sh = ub % 16;
      cy = 1'b0;
      case (op)
         3'd0: begin r = ua + ub; cy = (r > 65535); end
         3'd1: begin r = ua - ub; cy = (ua >= ub); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua << sh;
         3'd5: r = ua >> sh;
         3'd6: r = int'($signed(a)) >>> sh;
         default: r = (ua < ub) ? 1 : 0;
      endcase
      return {cy, r[15:0]};
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [16:0] stub;
      alu_share_ctrl #(.ALU_LAT(g == 0 ? 1 : 4), .PRIO_INIT(g == 1)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n[g]),
         .req0_valid (req_valid[g][0]),
         .req0_ready (req_ready[g][0]),
         .req0_op    (req_op[g][0]),
         .req0_a     (req_a[g][0]),
         .req0_b     (req_b[g][0]),
         .rsp0_valid (rsp_valid[g][0]),
         .rsp0_ready (rsp_ready[g][0]),
         .rsp0_data  (rsp_data[g][0]),
         .rsp0_carry (rsp_carry[g][0]),
         .req1_valid (req_valid[g][1]),
         .req1_ready (req_ready[g][1]),
         .req1_op    (req_op[g][1]),
         .req1_a     (req_a[g][1]),
         .req1_b     (req_b[g][1]),
         .rsp1_valid (rsp_valid[g][1]),
         .rsp1_ready (rsp_ready[g][1]),
         .rsp1_data  (rsp_data[g][1]),
         .rsp1_carry (rsp_carry[g][1]),
         .alu_op     (alu_op[g]),
         .alu_i0     (alu_i0[g]),
         .alu_i1     (alu_i1[g]),
         .alu_o      (alu_o[g]),
         .alu_carry  (alu_carry[g]),
         .busy       (busy[g]),
         .owner      (owner[g])
      );
      assign stub         = alu_stub(alu_op[g], alu_i0[g], alu_i1[g]);
      assign alu_o[g]     = stub[15:0];
      assign alu_carry[g] = stub[16];
   end

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [74:0] out_flat(input int i);
      return {busy[i], owner[i], alu_op[i], alu_i0[i], alu_i1[i],
              req_ready[i][0], req_ready[i][1], rsp_valid[i][0], rsp_valid[i][1],
              rsp_carry[i][0], rsp_carry[i][1], rsp_data[i][0], rsp_data[i][1]};
   endfunction

   task automatic idle_inputs(input int i);
      for (int k = 0; k < 2; k++) begin
         req_valid[i][k] = 1'b0;
         req_op[i][k]    = 3'd0;
         req_a[i][k]     = 16'd0;
         req_b[i][k]     = 16'd0;
         rsp_ready[i][k] = 1'b0;
      end
   endtask

   task automatic do_reset(input int i);
      @(negedge clk);
      idle_inputs(i);
      rst_n[i] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[i] = 1'b1;
   endtask

   task automatic set_req(input int i, input int k, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b);
      req_valid[i][k] = 1'b1;
      req_op[i][k]    = op;
      req_a[i][k]     = a;
      req_b[i][k]     = b;
   endtask

   // Waits for grant of an already-raised request, checks latency and result,
   // optionally holds off rsp_ready for 'hold' cycles, then takes the result.
   task automatic serve(input int i, input int k, input logic [15:0] exp_d, input logic exp_c,
                        input int hold, input string nm);
      int w;
      int n;
      w = 0;
      #1;
      while (req_ready[i][k] !== 1'b1 && w < 40) begin
         @(negedge clk);
         #1;
         w++;
      end
      checks++;
      if (req_ready[i][k] !== 1'b1) begin
         failures++;
         $display("FAIL %s_grant got=%b exp=1 (no grant in 40 cycles)", nm, req_ready[i][k]);
         req_valid[i][k] = 1'b0;
         return;
      end
      checks++;
      if (req_ready[i][1-k] !== 1'b0) begin
         failures++;
         $display("FAIL %s_other_ready got=%b exp=0", nm, req_ready[i][1-k]);
      end
      @(negedge clk);
      req_valid[i][k] = 1'b0;
      n = 1;
      #1;
      while (rsp_valid[i][k] !== 1'b1 && n < 40) begin
         checks++;
         if (busy[i] !== 1'b1 || owner[i] !== k[0]) begin
            failures++;
            $display("FAIL %s_busy_owner got=%b/%b exp=1/%0d", nm, busy[i], owner[i], k);
         end
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != lat_of(i) + 1) begin
         failures++;
         $display("FAIL %s_latency got=%0d exp=%0d", nm, n, lat_of(i) + 1);
      end
      checks++;
      if (rsp_data[i][k] !== exp_d) begin
         failures++;
         $display("FAIL %s_data got=%h exp=%h", nm, rsp_data[i][k], exp_d);
      end
      checks++;
      if (rsp_carry[i][k] !== exp_c) begin
         failures++;
         $display("FAIL %s_carry got=%b exp=%b", nm, rsp_carry[i][k], exp_c);
      end
      checks++;
      if (rsp_valid[i][1-k] !== 1'b0) begin
         failures++;
         $display("FAIL %s_other_rsp_valid got=%b exp=0", nm, rsp_valid[i][1-k]);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         #1;
         checks++;
         if (rsp_valid[i][k] !== 1'b1 || rsp_data[i][k] !== exp_d || rsp_carry[i][k] !== exp_c) begin
            failures++;
            $display("FAIL %s_hold cyc%0d got=%b/%h/%b exp=1/%h/%b", nm, h, rsp_valid[i][k],
                     rsp_data[i][k], rsp_carry[i][k], exp_d, exp_c);
         end
         checks++;
         if (req_ready[i][1-k] !== 1'b0) begin
            failures++;
            $display("FAIL %s_hold_other_ready cyc%0d got=%b exp=0", nm, h, req_ready[i][1-k]);
         end
      end
      rsp_ready[i][k] = 1'b1;
      @(negedge clk);
      rsp_ready[i][k] = 1'b0;
      #1;
      checks++;
      if (busy[i] !== 1'b0 || rsp_valid[i][k] !== 1'b0) begin
         failures++;
         $display("FAIL %s_release got busy=%b valid=%b exp=0/0", nm, busy[i], rsp_valid[i][k]);
      end
   endtask

   task automatic test_reset(input int i);
      @(negedge clk);
      idle_inputs(i);
      rst_n[i] = 1'b0;
      #1;
      checks++;
      if (out_flat(i) !== 75'd0) begin
         failures++;
         $display("FAIL reset_outputs inst%0d got=%h exp=0", i, out_flat(i));
      end
      repeat (2) @(negedge clk);
      rst_n[i] = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (out_flat(i) !== 75'd0) begin
         failures++;
         $display("FAIL post_reset_idle inst%0d got=%h exp=0", i, out_flat(i));
      end
   endtask

   task automatic test_add_sub();
      set_req(0, 0, 3'b000, 16'hFFFF, 16'h0001);
      serve(0, 0, 16'h0000, 1'b1, 0, "add_wrap");
      set_req(0, 1, 3'b001, 16'h0005, 16'h0003);
      serve(0, 1, 16'h0002, 1'b1, 0, "sub_pos");
      set_req(0, 1, 3'b001, 16'h0003, 16'h0005);
      serve(0, 1, 16'hFFFE, 1'b0, 0, "sub_neg");
      set_req(0, 1, 3'b111, 16'h0003, 16'h0005);
      serve(0, 1, 16'h0001, 1'b0, 0, "lt_masked");
      set_req(0, 0, 3'b011, 16'h00F0, 16'h000F);
      serve(0, 0, 16'h00FF, 1'b0, 0, "or_masked");
   endtask

   task automatic test_shift();
      set_req(0, 0, 3'b100, 16'h0001, 16'h0013);
      serve(0, 0, 16'h0008, 1'b0, 0, "sll_mask");
      set_req(0, 1, 3'b110, 16'h8000, 16'h0004);
      serve(0, 1, 16'hF800, 1'b0, 0, "sra");
      set_req(0, 0, 3'b101, 16'hF000, 16'h0024);
      serve(0, 0, 16'h0F00, 1'b0, 0, "srl_mask");
   endtask

   task automatic test_contention();
      do_reset(0);
      set_req(0, 0, 3'b010, 16'h0F0F, 16'h00FF);
      set_req(0, 1, 3'b011, 16'h0F00, 16'h00FF);
      serve(0, 0, 16'h000F, 1'b0, 0, "cont_a_first0");
      serve(0, 1, 16'h0FFF, 1'b0, 0, "cont_a_then1");
      set_req(0, 0, 3'b000, 16'h0001, 16'h0002);
      serve(0, 0, 16'h0003, 1'b0, 0, "cont_solo0");
      set_req(0, 0, 3'b010, 16'h0F0F, 16'h00FF);
      set_req(0, 1, 3'b011, 16'h0F00, 16'h00FF);
      serve(0, 1, 16'h0FFF, 1'b0, 0, "cont_b_first1");
      serve(0, 0, 16'h000F, 1'b0, 0, "cont_b_then0");
   endtask

   task automatic test_backpressure();
      do_reset(0);
      set_req(0, 0, 3'b000, 16'h1234, 16'h1111);
      set_req(0, 1, 3'b001, 16'h0010, 16'h0001);
      serve(0, 0, 16'h2345, 1'b0, 5, "bp0");
      checks++;
      if (req_ready[0][1] !== 1'b1) begin
         failures++;
         $display("FAIL bp_next_grant got=%b exp=1", req_ready[0][1]);
      end
      serve(0, 1, 16'h000F, 1'b1, 0, "bp1");
   endtask

   task automatic test_reset_mid_exec();
      do_reset(1);
      set_req(1, 1, 3'b000, 16'h0001, 16'h0001);
      serve(1, 1, 16'h0002, 1'b0, 0, "rx_warm1");
      set_req(1, 0, 3'b000, 16'h7777, 16'h1111);
      #1;
      checks++;
      if (req_ready[1][0] !== 1'b1) begin
         failures++;
         $display("FAIL rx_grant0 got=%b exp=1", req_ready[1][0]);
      end
      @(negedge clk);
      req_valid[1][0] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b0;
      #1;
      checks++;
      if (out_flat(1) !== 75'd0) begin
         failures++;
         $display("FAIL rx_reset_outputs got=%h exp=0", out_flat(1));
      end
      @(negedge clk);
      rst_n[1] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (rsp_valid[1][0] !== 1'b0 || rsp_valid[1][1] !== 1'b0 || busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL rx_no_rsp cyc%0d got=%b%b busy=%b exp=00 busy=0", c,
                     rsp_valid[1][0], rsp_valid[1][1], busy[1]);
         end
      end
      set_req(1, 0, 3'b001, 16'h0100, 16'h0001);
      set_req(1, 1, 3'b100, 16'h0003, 16'h0002);
      #1;
      checks++;
      if (req_ready[1][1] !== 1'b1 || req_ready[1][0] !== 1'b0) begin
         failures++;
         $display("FAIL rx_ptr_init got=%b%b exp=10", req_ready[1][1], req_ready[1][0]);
      end
      serve(1, 1, 16'h000C, 1'b0, 0, "rx_after1");
      serve(1, 0, 16'h00FF, 1'b1, 0, "rx_after0");
   endtask

   // Randomized traffic against a transaction-level model: at most one
   // transaction in flight, response available LAT+1 cycles after acceptance,
   // tie won by whichever requester was not served last.
   task automatic test_random(input int i, input int ncyc);
      bit          pend;
      int          own, prio, rdy, acc;
      bit          took [2];
      logic [16:0] exp;
      logic        exp_rdy, exp_rv;
      do_reset(i);
      pend    = 1'b0;
      own     = 0;
      rdy     = 0;
      prio    = prio_of(i);
      took[0] = 1'b0;
      took[1] = 1'b0;
      exp     = '0;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         for (int k = 0; k < 2; k++) begin
            if (!req_valid[i][k] || took[k]) begin
               req_valid[i][k] = ($urandom_range(0, 2) != 0);
               req_op[i][k]    = 3'($urandom_range(0, 7));
               req_a[i][k]     = 16'($urandom);
               req_b[i][k]     = 16'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[i][k] = 1'b0;
            end
            rsp_ready[i][k] = 1'($urandom_range(0, 1));
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            exp_rdy = !pend && req_valid[i][k] && (prio == k || !req_valid[i][1-k]);
            exp_rv  = pend && own == k && cyc >= rdy;
            checks++;
            if (req_ready[i][k] !== exp_rdy) begin
               failures++;
               $display("FAIL rnd_ready inst%0d req%0d cyc%0d got=%b exp=%b", i, k, cyc,
                        req_ready[i][k], exp_rdy);
            end
            checks++;
            if (rsp_valid[i][k] !== exp_rv) begin
               failures++;
               $display("FAIL rnd_rsp_valid inst%0d rsp%0d cyc%0d got=%b exp=%b", i, k, cyc,
                        rsp_valid[i][k], exp_rv);
            end
            if (exp_rv) begin
               checks++;
               if (rsp_data[i][k] !== exp[15:0] || rsp_carry[i][k] !== exp[16]) begin
                  failures++;
                  $display("FAIL rnd_result inst%0d rsp%0d cyc%0d got=%h/%b exp=%h/%b", i, k, cyc,
                           rsp_data[i][k], rsp_carry[i][k], exp[15:0], exp[16]);
               end
            end
         end
         checks++;
         if (busy[i] !== pend || (pend && owner[i] !== own[0])) begin
            failures++;
            $display("FAIL rnd_busy_owner inst%0d cyc%0d got=%b/%b exp=%b/%0d", i, cyc,
                     busy[i], owner[i], pend, own);
         end
         acc = -1;
         for (int k = 0; k < 2; k++) begin
            if (!pend && req_valid[i][k] && (prio == k || !req_valid[i][1-k])) acc = k;
         end
         took[0] = 1'b0;
         took[1] = 1'b0;
         if (pend && cyc >= rdy && rsp_ready[i][own]) begin
            pend = 1'b0;
            prio = 1 - own;
         end else if (acc >= 0) begin
            pend      = 1'b1;
            own       = acc;
            rdy       = cyc + lat_of(i) + 1;
            exp       = ref_rsp(req_op[i][acc], req_a[i][acc], req_b[i][acc]);
            took[acc] = 1'b1;
         end
         @(negedge clk);
      end
      idle_inputs(i);
   endtask

   initial begin
      clk = 1'b0;
      for (int i = 0; i < NI; i++) begin
         rst_n[i] = 1'b0;
         idle_inputs(i);
      end
      test_reset(0);
      test_add_sub();
      test_shift();
      test_contention();
      test_backpressure();
      test_reset_mid_exec();
      test_random(0, 600);
      test_random(1, 600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
